// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared SAT solver types for the BCP clause path
package sat_pkg;

  localparam int DEF_VAR_W       = 7;
  localparam int DEF_CLAUSE_ID_W = 10;

  typedef enum logic [1:0] {
    SAT        = 2'd0,
    UNIT       = 2'd1,
    CONFLICT   = 2'd2,
    UNRESOLVED = 2'd3
  } clause_status_t;

  typedef struct packed {
    logic [DEF_VAR_W-1:0]       lit_var;
    logic                       val;
    logic [DEF_CLAUSE_ID_W-1:0] clause_id;
  } implication_t;

endpackage

// File: rtl/clause_eval_fifo.sv
// rtl/clause_eval_fifo.sv - synchronous implication FIFO with count and clear
module clause_eval_fifo
  import sat_pkg::*;
#(
  parameter type T          = implication_t,
  parameter int  DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && (r_count != CW'(DEPTH));
  assign w_pop  = pop && (r_count != '0);
  assign count  = r_count;
  // Head reads as zero when empty so the outputs are clean after reset or clear.
  assign head   = (r_count != '0) ? r_mem[r_rd] : '0;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/clause_eval_pipe.sv
// rtl/clause_eval_pipe.sv - two-stage streaming clause classifier with implication FIFO
module clause_eval_pipe
  import sat_pkg::*;
#(
  parameter int  NUM_VARIABLE   = 128,
  parameter int  VAR_PER_CLAUSE = 5,
  parameter int  CLAUSE_ID_W    = DEF_CLAUSE_ID_W,
  parameter int  FIFO_DEPTH     = 4,
  localparam int VAR_W          = $clog2(NUM_VARIABLE),
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CLAUSE_ID_W-1:0]            in_clause_id,
  input  logic [VAR_PER_CLAUSE-1:0]         in_mask,
  input  logic [VAR_PER_CLAUSE-1:0]         in_pole,
  input  logic [VAR_PER_CLAUSE-1:0]         in_unassign,
  input  logic [VAR_PER_CLAUSE-1:0]         in_val,
  input  logic [VAR_PER_CLAUSE*VAR_W-1:0]   in_var,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [VAR_W-1:0]                  out_var,
  output logic                              out_val,
  output logic [CLAUSE_ID_W-1:0]            out_clause_id,
  output logic                              conflict,
  output logic [CLAUSE_ID_W-1:0]            conflict_clause_id,
  input  logic                              clear_conflict,
  input  logic                              flush,
  output logic                              busy,
  output logic [31:0]                       num_evaluated
);

  typedef struct packed {
    logic [VAR_W-1:0]       lit_var;
    logic                   val;
    logic [CLAUSE_ID_W-1:0] clause_id;
  } impl_t;

  logic                            r_s1_valid;
  logic [VAR_PER_CLAUSE-1:0]       r_s1_true;
  logic [VAR_PER_CLAUSE-1:0]       r_s1_unas;
  logic [VAR_PER_CLAUSE-1:0]       r_s1_pole;
  logic [VAR_PER_CLAUSE*VAR_W-1:0] r_s1_var;
  logic [CLAUSE_ID_W-1:0]          r_s1_id;
  logic                            r_s2_valid;
  clause_status_t                  r_s2_status;
  impl_t                           r_s2_impl;
  logic                            r_conflict;
  logic [CLAUSE_ID_W-1:0]          r_conflict_id;
  logic [31:0]                     r_num_eval;

  logic                            w_accept;
  logic [1:0]                      w_cnt;
  logic [VAR_W-1:0]                w_k_var;
  logic                            w_k_val;
  clause_status_t                  w_status;
  logic                            w_s2_conflict;
  logic                            w_s2_unit;
  logic                            w_clear;
  logic [CNT_W-1:0]                w_count;
  logic [CNT_W:0]                  w_used;
  impl_t                           w_head;

  assign w_accept = in_valid & in_ready;

  // Saturating unassigned count; the lowest unassigned slot supplies the implication.
  always_comb begin
    w_cnt   = 2'd0;
    w_k_var = '0;
    w_k_val = 1'b0;
    for (int i = VAR_PER_CLAUSE - 1; i >= 0; i--) begin
      if (r_s1_unas[i]) begin
        w_k_var = r_s1_var[i*VAR_W +: VAR_W];
        w_k_val = r_s1_pole[i];
        if (w_cnt != 2'd2) w_cnt = w_cnt + 2'd1;
      end
    end
    if (|r_s1_true)         w_status = SAT;
    else if (w_cnt == 2'd0) w_status = CONFLICT;
    else if (w_cnt == 2'd1) w_status = UNIT;
    else                    w_status = UNRESOLVED;
  end

  assign w_s2_conflict = r_s2_valid & (r_s2_status == CONFLICT) & ~flush;
  assign w_s2_unit     = r_s2_valid & (r_s2_status == UNIT) & ~flush;
  assign w_clear       = flush | w_s2_conflict;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_conflict    <= 1'b0;
      r_conflict_id <= '0;
      r_num_eval    <= '0;
    end else begin
      r_s1_valid <= w_accept & ~w_clear;
      r_s2_valid <= r_s1_valid & ~w_clear;
      if (r_s2_valid & ~flush) r_num_eval <= r_num_eval + 32'd1;
      if (w_s2_conflict) begin
        r_conflict <= 1'b1;
        if (!r_conflict || clear_conflict) r_conflict_id <= r_s2_impl.clause_id;
      end else if (clear_conflict) begin
        r_conflict    <= 1'b0;
        r_conflict_id <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_s1_true <= in_mask & ~in_unassign & ~(in_val ^ in_pole);
      r_s1_unas <= in_mask & in_unassign;
      r_s1_pole <= in_pole;
      r_s1_var  <= in_var;
      r_s1_id   <= in_clause_id;
    end
    if (r_s1_valid) begin
      r_s2_status <= w_status;
      r_s2_impl   <= '{lit_var: w_k_var, val: w_k_val, clause_id: r_s1_id};
    end
  end

  clause_eval_fifo #(
    .T     (impl_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .push      (w_s2_unit),
    .push_data (r_s2_impl),
    .pop       (out_valid & out_ready),
    .head      (w_head),
    .count     (w_count)
  );

  // Credit counts every clause that could still land in the FIFO.
  assign w_used   = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_s1_valid) + (CNT_W+1)'(r_s2_valid);
  assign in_ready = ~r_conflict & ~flush & (w_used < (CNT_W+1)'(FIFO_DEPTH));

  assign out_valid          = (w_count != '0);
  assign out_var            = w_head.lit_var;
  assign out_val            = w_head.val;
  assign out_clause_id      = w_head.clause_id;
  assign conflict           = r_conflict;
  assign conflict_clause_id = r_conflict_id;
  assign busy               = r_s1_valid | r_s2_valid | out_valid;
  assign num_evaluated      = r_num_eval;

endmodule
